// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU/MDU: op codes,
// FSM state encoding and default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One bit per cycle; done is high during the last step, hi/lo carry that step's value.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   m;
    logic               div_mode;
    logic               busy;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     t;
    logic [WIDTH:0]     diff;
    logic               ge;

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo into the partial remainder.
    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
        t    = {acc_hi, acc_lo[WIDTH-1]};
        diff = t - {1'b0, m};
        ge   = (t >= {1'b0, m});
        if (div_mode) begin
            hi = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
            lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            hi = sum[WIDTH:1];
            lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    assign done = busy && (cnt == SHAMT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            div_mode <= 1'b0;
            m        <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            div_mode <= mode;
            m        <= b;
            acc_hi   <= '0;
            acc_lo   <= a;
        end else if (busy) begin
            acc_hi <= hi;
            acc_lo <= lo;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative MULU/DIVU; valid/ready on both sides,
// results registered and held until the consumer accepts them.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow
);

    state_t             state;
    logic [WIDTH-1:0]   add_res;
    logic [WIDTH-1:0]   sub_res;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic               start;
    logic               done;
    logic [WIDTH-1:0]   mdu_hi;
    logic [WIDTH-1:0]   mdu_lo;

    assign shamt   = b[SHAMT_W-1:0];
    assign add_res = a + b;
    assign sub_res = a - b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sub_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign start     = in_ready && in_valid && (op == OP_MULU || op == OP_DIVU);

    alu_mdu_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (op == OP_DIVU),
        .a     (a),
        .b     (b),
        .done  (done),
        .hi    (mdu_hi),
        .lo    (mdu_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            result   <= '0;
            hi       <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MULU) begin
                            state <= ST_MUL;
                        end else if (op == OP_DIVU) begin
                            state <= ST_DIV;
                        end else begin
                            result   <= alu_res;
                            hi       <= '0;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (done) begin
                        result   <= mdu_lo;
                        hi       <= mdu_hi;
                        zero     <= (mdu_lo == '0);
                        overflow <= 1'b0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
